sobel_edge_capture: RTL and testbench

SOBEL_EDGE_CAPTURE -- requirements
Module: sobel_edge_capture

---
 rtl/sobel_edge_capture.sv | 183 ++++++++++++++++++
 tb/tb_sobel_edge_capture.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_capture.sv
// Captures interior Sobel magnitudes of one frame into a small RAM, then
// streams them back in raster order with saturation and a threshold edge flag.
module sobel_edge_capture #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [2:0]            in_row,
    input  logic [2:0]            in_col,
    input  logic [DATA_WIDTH+2:0] in_mag,
    input  logic                  in_done,
    input  logic [DATA_WIDTH+2:0] thresh,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            out_row,
    output logic [2:0]            out_col,
    output logic [DATA_WIDTH-1:0] out_pix,
    output logic                  out_edge,
    output logic [5:0]            edge_count,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int MAG_W  = DATA_WIDTH + 3;
    localparam int COLS   = IMG_WIDTH - 2;
    localparam int ROWS   = IMG_HEIGHT - 2;
    localparam int N      = ROWS * COLS;
    localparam int ADDR_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W  = $clog2(N + 1);
    localparam logic [2:0]       ROW_LAST = 3'(IMG_HEIGHT - 2);
    localparam logic [2:0]       COL_LAST = 3'(IMG_WIDTH - 2);
    localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N);

    typedef enum logic [1:0] {IDLE, CAPTURE, READOUT} state_t;

    state_t               state_q, state_d;
    logic [MAG_W-1:0]     thresh_q, thresh_d;
    logic [N-1:0]         flags_q, flags_d;
    logic                 out_valid_q, out_valid_d;
    logic [2:0]           out_row_q, out_row_d;
    logic [2:0]           out_col_q, out_col_d;
    logic                 rd_flag_q, rd_flag_d;
    logic [CNT_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [2:0]           fr_row_q, fr_row_d;
    logic [2:0]           fr_col_q, fr_col_d;
    logic [5:0]           edge_count_q, edge_count_d;
    logic                 frame_done_q, frame_done_d;

    logic [DATA_WIDTH:0]  mem [N];
    logic [DATA_WIDTH:0]  ram_q;

    logic                  accept, wr_en, rd_en, xfer;
    logic [ADDR_W-1:0]     wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] mag_sat;
    logic [MAG_W-1:0]      thr_eff;
    logic [DATA_WIDTH:0]   wr_data;

    assign accept  = in_valid && (in_row >= 3'd1) && (in_row <= ROW_LAST)
                              && (in_col >= 3'd1) && (in_col <= COL_LAST);
    assign wr_addr = ADDR_W'((32'(in_row) - 32'd1) * 32'(COLS) + 32'(in_col) - 32'd1);
    assign rd_addr = ADDR_W'(rd_ptr_q);
    assign mag_sat = (|in_mag[MAG_W-1:DATA_WIDTH]) ? {DATA_WIDTH{1'b1}} : in_mag[DATA_WIDTH-1:0];
    // The first sample of a frame is judged against the threshold latched with it.
    assign thr_eff = (state_q == IDLE) ? thresh : thresh_q;
    assign wr_data = {(in_mag >= thr_eff), mag_sat};
    assign xfer    = out_valid_q && out_ready;

    always_comb begin
        state_d      = state_q;
        thresh_d     = thresh_q;
        flags_d      = flags_q;
        out_valid_d  = out_valid_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        rd_flag_d    = rd_flag_q;
        rd_ptr_d     = rd_ptr_q;
        fr_row_d     = fr_row_q;
        fr_col_d     = fr_col_q;
        edge_count_d = edge_count_q;
        frame_done_d = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_en            = 1'b1;
                    flags_d[wr_addr] = 1'b1;
                    thresh_d         = thresh;
                    state_d          = CAPTURE;
                end
            end
            CAPTURE: begin
                if (accept) begin
                    wr_en            = 1'b1;
                    flags_d[wr_addr] = 1'b1;
                end
                if (in_done) begin
                    state_d      = READOUT;
                    rd_ptr_d     = '0;
                    fr_row_d     = 3'd1;
                    fr_col_d     = 3'd1;
                    edge_count_d = '0;
                end
            end
            READOUT: begin
                if (xfer && out_edge)
                    edge_count_d = edge_count_q + 6'd1;
                if (!out_valid_q || xfer) begin
                    if (rd_ptr_q < N_CNT) begin
                        rd_en       = 1'b1;
                        rd_flag_d   = flags_q[rd_addr];
                        out_valid_d = 1'b1;
                        out_row_d   = fr_row_q;
                        out_col_d   = fr_col_q;
                        rd_ptr_d    = rd_ptr_q + 1'b1;
                        if (fr_col_q == COL_LAST) begin
                            fr_col_d = 3'd1;
                            fr_row_d = fr_row_q + 3'd1;
                        end else begin
                            fr_col_d = fr_col_q + 3'd1;
                        end
                    end else begin
                        out_valid_d  = 1'b0;
                        rd_flag_d    = 1'b0;
                        flags_d      = '0;
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            thresh_q     <= '0;
            flags_q      <= '0;
            out_valid_q  <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            rd_flag_q    <= 1'b0;
            rd_ptr_q     <= '0;
            fr_row_q     <= 3'd1;
            fr_col_q     <= 3'd1;
            edge_count_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            thresh_q     <= thresh_d;
            flags_q      <= flags_d;
            out_valid_q  <= out_valid_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            rd_flag_q    <= rd_flag_d;
            rd_ptr_q     <= rd_ptr_d;
            fr_row_q     <= fr_row_d;
            fr_col_q     <= fr_col_d;
            edge_count_q <= edge_count_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage is never reset; the written flag masks stale contents on readout.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            ram_q <= mem[rd_addr];
    end

    assign out_valid  = out_valid_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign out_pix    = rd_flag_q ? ram_q[DATA_WIDTH-1:0] : '0;
    assign out_edge   = rd_flag_q & ram_q[DATA_WIDTH];
    assign edge_count = edge_count_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_sobel_edge_capture.sv
// Directed bench for sobel_edge_capture: table of single-pixel frames plus
// hand-written full-frame, backpressure, border, duplicate and reset sequences.
module tb_sobel_edge_capture;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  in_row, in_col;
    logic [10:0] in_mag, thresh;
    logic        in_done;
    logic        out_valid, out_ready;
    logic [2:0]  out_row, out_col;
    logic [7:0]  out_pix;
    logic        out_edge;
    logic [5:0]  edge_count;
    logic        busy, frame_done;

    always #5 clk = ~clk;

    sobel_edge_capture #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_row(in_row), .in_col(in_col),
        .in_mag(in_mag), .in_done(in_done), .thresh(thresh), .out_valid(out_valid),
        .out_ready(out_ready), .out_row(out_row), .out_col(out_col), .out_pix(out_pix),
        .out_edge(out_edge), .edge_count(edge_count), .busy(busy), .frame_done(frame_done)
    );

    typedef struct {
        int row; int col; int mag; int thr;
        int exp_pix; int exp_edge; int exp_cnt;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;
    int   m_mag [8][8];
    bit   m_wr  [8][8];
    int   m_thr;
    bit   m_started;
    int   cap_pix [36];
    int   cap_edge[36];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                m_mag[r][c] = 0;
                m_wr[r][c]  = 1'b0;
            end
        m_thr     = 0;
        m_started = 1'b0;
    endtask

    task automatic write_px(input int r, input int c, input int m, input int th);
        in_valid = 1'b1;
        in_row   = 3'(r);
        in_col   = 3'(c);
        in_mag   = 11'(m);
        thresh   = 11'(th);
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("write row %0d col %0d mag %0d thresh %0d", r, c, m, th);
        if (r >= 1 && r <= 6 && c >= 1 && c <= 6) begin
            if (!m_started) begin
                m_started = 1'b1;
                m_thr     = th;
            end
            m_mag[r][c] = m;
            m_wr[r][c]  = 1'b1;
        end
    endtask

    task automatic send_done();
        in_done = 1'b1;
        @(posedge clk); #1;
        in_done = 1'b0;
        chk("valid_low_on_entry", int'(out_valid), 0);
        chk("busy_in_readout", int'(busy), 1);
        @(posedge clk); #1;
        chk("valid_rise_one_cycle", int'(out_valid), 1);
    endtask

    // Drains the readout; returns in the frame_done cycle, or right after
    // beat stop_at transfers when stop_at > 0.
    task automatic collect(input int stall_at, input int stall_len, input int stop_at);
        int beats = 0;
        int stalled = 0;
        int exp_cnt = 0;
        int er, ec, ep, ee;
        bit prev_stall = 1'b0;
        bit done = 1'b0;
        logic [2:0] pr, pc;
        logic [7:0] pp;
        logic       pe;
        for (int r = 1; r <= 6; r++)
            for (int c = 1; c <= 6; c++)
                if (m_wr[r][c] && m_mag[r][c] >= m_thr) exp_cnt++;
        for (int cyc = 0; cyc < 500 && !done; cyc++) begin
            if (beats == stall_at && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            if (prev_stall) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_row", int'(out_row), int'(pr));
                chk("hold_col", int'(out_col), int'(pc));
                chk("hold_pix", int'(out_pix), int'(pp));
                chk("hold_edge", int'(out_edge), int'(pe));
            end
            prev_stall = 1'b0;
            if (out_valid && out_ready) begin
                er = beats / 6 + 1;
                ec = beats % 6 + 1;
                ep = m_wr[er][ec] ? ((m_mag[er][ec] > 255) ? 255 : m_mag[er][ec]) : 0;
                ee = (m_wr[er][ec] && m_mag[er][ec] >= m_thr) ? 1 : 0;
                chk("beat_row", int'(out_row), er);
                chk("beat_col", int'(out_col), ec);
                chk("beat_pix", int'(out_pix), ep);
                chk("beat_edge", int'(out_edge), ee);
                cap_pix[beats]  = int'(out_pix);
                cap_edge[beats] = int'(out_edge);
                $display("beat %0d row %0d col %0d pix %0d edge %0d", beats, out_row, out_col, out_pix, out_edge);
                beats++;
            end else if (out_valid) begin
                prev_stall = 1'b1;
                pr = out_row; pc = out_col; pp = out_pix; pe = out_edge;
            end
            @(posedge clk); #1;
            if (stop_at > 0 && beats == stop_at) begin
                done = 1'b1;
            end else if (beats == 36) begin
                chk("frame_done_pulse", int'(frame_done), 1);
                chk("idle_after_frame", int'(busy), 0);
                chk("valid_low_after_frame", int'(out_valid), 0);
                chk("edge_count_final", int'(edge_count), exp_cnt);
                done = 1'b1;
            end else begin
                chk("no_early_frame_done", int'(frame_done), 0);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL collect_timeout: got %0d beats expected 36", beats);
        end
        out_ready = 1'b1;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        chk("frame_done_one_cycle", int'(frame_done), 0);
        chk("stays_idle", int'(busy), 0);
    endtask

    task automatic full_frame();
        m_reset();
        for (int r = 1; r <= 6; r++)
            for (int c = 1; c <= 6; c++)
                write_px(r, c, 40 * r + c, 100);
    endtask

    initial begin
        vecs[0] = '{1, 1, 1500, 2000, 255, 0, 0};
        vecs[1] = '{1, 1, 1500, 1500, 255, 1, 1};
        vecs[2] = '{2, 2,   50,  100,  50, 0, 0};
        vecs[3] = '{6, 6,  255,  255, 255, 1, 1};
        vecs[4] = '{6, 1,  256,    0, 255, 1, 1};
        vecs[5] = '{1, 6,   99,  100,  99, 0, 0};
        vecs[6] = '{3, 4,    0,    0,   0, 1, 1};
        vecs[7] = '{4, 5, 2047, 2047, 255, 1, 1};

        rst = 1'b0; in_valid = 1'b0; in_row = '0; in_col = '0;
        in_mag = '0; thresh = '0; in_done = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_row", int'(out_row), 0);
        chk("rst_col", int'(out_col), 0);
        chk("rst_pix", int'(out_pix), 0);
        chk("rst_edge", int'(out_edge), 0);
        chk("rst_count", int'(edge_count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        rst = 1'b1;

        in_done = 1'b1;
        @(posedge clk); #1;
        in_done = 1'b0;
        chk("done_ignored_in_idle", int'(busy), 0);

        // Full frame: rows 1-2 below threshold, rows 3-6 above.
        full_frame();
        chk("busy_in_capture", int'(busy), 1);
        chk("valid_low_in_capture", int'(out_valid), 0);
        send_done();
        collect(-1, 0, 0);
        chk("full_edge_count", int'(edge_count), 24);
        idle_cycle();
        chk("edge_count_holds", int'(edge_count), 24);

        // Same frame with a 5-cycle stall on beat 10.
        full_frame();
        send_done();
        collect(10, 5, 0);
        idle_cycle();

        // Border samples are ignored and do not start a capture.
        m_reset();
        write_px(0, 3, 500, 10);
        write_px(7, 7, 500, 10);
        write_px(4, 0, 500, 10);
        chk("border_no_capture", int'(busy), 0);
        write_px(2, 2, 50, 100);
        send_done();
        collect(-1, 0, 0);
        chk("gap_pix_2_2", cap_pix[7], 50);
        idle_cycle();

        // Duplicate writes: last one wins; a sample in the frame_done cycle restarts capture.
        m_reset();
        write_px(3, 3, 200, 100);
        write_px(3, 3, 10, 100);
        send_done();
        collect(-1, 0, 0);
        chk("dup_pix", cap_pix[14], 10);
        chk("dup_edge", cap_edge[14], 0);
        chk("dup_count", int'(edge_count), 0);
        m_reset();
        write_px(2, 3, 77, 60);
        chk("capture_from_frame_done", int'(busy), 1);
        chk("frame_done_dropped", int'(frame_done), 0);
        send_done();
        collect(-1, 0, 0);
        chk("restart_pix", cap_pix[8], 77);
        idle_cycle();

        for (int i = 0; i < 8; i++) begin
            m_reset();
            write_px(vecs[i].row, vecs[i].col, vecs[i].mag, vecs[i].thr);
            send_done();
            collect(-1, 0, 0);
            chk("vec_pix", cap_pix[(vecs[i].row - 1) * 6 + vecs[i].col - 1], vecs[i].exp_pix);
            chk("vec_edge", cap_edge[(vecs[i].row - 1) * 6 + vecs[i].col - 1], vecs[i].exp_edge);
            chk("vec_count", int'(edge_count), vecs[i].exp_cnt);
            idle_cycle();
        end

        // Reset in the middle of readout, then a clean sparse frame.
        full_frame();
        send_done();
        collect(-1, 0, 20);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_row", int'(out_row), 0);
        chk("midrst_col", int'(out_col), 0);
        chk("midrst_pix", int'(out_pix), 0);
        chk("midrst_edge", int'(out_edge), 0);
        chk("midrst_count", int'(edge_count), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_frame_done", int'(frame_done), 0);
        rst = 1'b1;
        m_reset();
        write_px(5, 5, 77, 50);
        send_done();
        collect(-1, 0, 0);
        chk("post_rst_count", int'(edge_count), 1);
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
